wb_regfile: RTL and testbench

Write-back stage and architectural register file of the five-stage MIPS pipeline. Consumes the MEM/WB pipeline register outputs, selects the write-back value by `MemToReg`, and commits it to a 32×32 register file. Serves the ID stage's two read ports with same-cycle write-through bypass. Exports a forwarding tap for the hazard unit and a committed-write counter for debug.

---
 rtl/cpu_pkg.sv | 8 +
 rtl/wb_mux.sv | 21 ++
 rtl/wb_regfile.sv | 71 +++++++
 tb/tb_wb_regfile.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline constants: write-back source encoding and register file geometry.
package cpu_pkg;
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int NUM_REGS = 32;
endpackage

// File: rtl/wb_mux.sv
// Write-back source selector; the reserved code falls back to the ALU result.
module wb_mux
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] alu,
  input  logic [DATA_W-1:0] mem,
  input  logic [DATA_W-1:0] link,
  output logic [DATA_W-1:0] y
);
  always_comb begin
    y = alu;
    case (sel)
      WB_MEM:  y = mem;
      WB_LINK: y = link;
      default: y = alu;
    endcase
  end
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus 32x32 register file with write-through read bypass,
// forwarding tap and committed-write counter.
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        write_addr_in,
  input  logic [DATA_W-1:0] alu_out_in,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] pc_plus4_in,
  input  logic [1:0]        MemToReg_in,
  input  logic              RegWrite_in,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              fwd_valid,
  output logic [4:0]        fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  wb_count
);
  logic [DATA_W-1:0] wb_value;
  logic [DATA_W-1:0] regs [1:NUM_REGS-1];
  logic              we;

  wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
    .sel  (MemToReg_in),
    .alu  (alu_out_in),
    .mem  (mem_data_in),
    .link (pc_plus4_in),
    .y    (wb_value)
  );

  // Reset low forces we low, so nothing commits, bypasses or forwards.
  assign we = RegWrite_in && (write_addr_in != REG_ZERO) && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
      wb_count <= '0;
    end else if (we) begin
      regs[write_addr_in] <= wb_value;
      wb_count            <= wb_count + CNT_W'(1);
    end
  end

  always_comb begin
    rs_data = '0;
    if (rs_addr != REG_ZERO) rs_data = (we && rs_addr == write_addr_in) ? wb_value : regs[rs_addr];
  end

  always_comb begin
    rt_data = '0;
    if (rt_addr != REG_ZERO) rt_data = (we && rt_addr == write_addr_in) ? wb_value : regs[rt_addr];
  end

  always_comb begin
    dbg_data = '0;
    if (dbg_addr != REG_ZERO) dbg_data = regs[dbg_addr];
  end

  assign fwd_valid = we;
  assign fwd_addr  = reset ? write_addr_in : 5'd0;
  assign fwd_data  = reset ? wb_value : '0;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile; a second 4-bit-counter instance shares the stimulus.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  write_addr_in = '0;
  logic [31:0] alu_out_in = '0, mem_data_in = '0, pc_plus4_in = '0;
  logic [1:0]  MemToReg_in = '0;
  logic        RegWrite_in = 1'b0;
  logic [4:0]  rs_addr = '0, rt_addr = '0, dbg_addr = '0;
  logic [31:0] rs_data, rt_data, fwd_data, dbg_data, wb_count;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] rs4, rt4, fd4, dd4;
  logic        fv4;
  logic [4:0]  fa4;
  logic [3:0]  wb_count4;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_regfile #(.DATA_W(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .write_addr_in(write_addr_in), .alu_out_in(alu_out_in),
    .mem_data_in(mem_data_in), .pc_plus4_in(pc_plus4_in), .MemToReg_in(MemToReg_in),
    .RegWrite_in(RegWrite_in), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data),
    .rt_data(rt_data), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wb_count(wb_count)
  );

  wb_regfile #(.DATA_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .write_addr_in(write_addr_in), .alu_out_in(alu_out_in),
    .mem_data_in(mem_data_in), .pc_plus4_in(pc_plus4_in), .MemToReg_in(MemToReg_in),
    .RegWrite_in(RegWrite_in), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs4),
    .rt_data(rt4), .fwd_valid(fv4), .fwd_addr(fa4), .fwd_data(fd4),
    .dbg_addr(dbg_addr), .dbg_data(dd4), .wb_count(wb_count4)
  );

  // Inputs change 1ns after a rising edge; reset is released away from the edge.
  task automatic reset_pulse();
    reset = 1'b0;
    RegWrite_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic commit(input logic [4:0] addr, input logic [1:0] sel,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc);
    write_addr_in = addr;
    MemToReg_in   = sel;
    alu_out_in    = alu;
    mem_data_in   = mem;
    pc_plus4_in   = pc;
    RegWrite_in   = 1'b1;
    @(posedge clk);
    #1 RegWrite_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    write_addr_in = 5'd5;
    alu_out_in = 32'h99;
    MemToReg_in = 2'b00;
    RegWrite_in = 1'b1;
    rs_addr = 5'd5;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (fwd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fwd_valid got %0b want 0", fwd_valid); end
    n_checks++;
    if (fwd_data !== 32'h0) begin n_fail++; $display("FAIL reset_fwd_data got %h want 0", fwd_data); end
    n_checks++;
    if (rs_data !== 32'h0) begin n_fail++; $display("FAIL reset_rs_bypass got %h want 0", rs_data); end
    n_checks++;
    if (wb_count !== 32'h0) begin n_fail++; $display("FAIL reset_count got %0d want 0", wb_count); end
    for (int a = 0; a < 32; a++) begin
      dbg_addr = a[4:0];
      #1;
      n_checks++;
      if (dbg_data !== 32'h0) begin n_fail++; $display("FAIL reset_dbg r%0d got %h want 0", a, dbg_data); end
    end
    RegWrite_in = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    commit(5'd5, 2'b00, 32'h1234, 32'h0, 32'h0);
    dbg_addr = 5'd5;
    #1;
    n_checks++;
    if (dbg_data !== 32'h1234) begin n_fail++; $display("FAIL first_write got %h want 00001234", dbg_data); end
    n_checks++;
    if (wb_count !== 32'd1) begin n_fail++; $display("FAIL first_count got %0d want 1", wb_count); end
  endtask

  task automatic test_source_select();
    logic [31:0] exp_v [4];
    exp_v = '{32'hA, 32'hB, 32'hC, 32'hA};
    reset_pulse();
    dbg_addr = 5'd8;
    for (int s = 0; s < 4; s++) begin
      commit(5'd8, s[1:0], 32'hA, 32'hB, 32'hC);
      #1;
      n_checks++;
      if (dbg_data !== exp_v[s]) begin n_fail++; $display("FAIL src_sel%0d got %h want %h", s, dbg_data, exp_v[s]); end
    end
    n_checks++;
    if (wb_count !== 32'd4) begin n_fail++; $display("FAIL src_count got %0d want 4", wb_count); end
  endtask

  task automatic test_bypass();
    commit(5'd3, 2'b00, 32'h1111_1111, 32'h0, 32'h0);
    write_addr_in = 5'd3;
    MemToReg_in = 2'b01;
    mem_data_in = 32'hDEAD_BEEF;
    alu_out_in = 32'h5555_5555;
    RegWrite_in = 1'b1;
    rs_addr = 5'd3;
    rt_addr = 5'd3;
    dbg_addr = 5'd3;
    #1;
    n_checks++;
    if (rs_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_rs got %h want deadbeef", rs_data); end
    n_checks++;
    if (rt_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_rt got %h want deadbeef", rt_data); end
    n_checks++;
    if (dbg_data !== 32'h1111_1111) begin n_fail++; $display("FAIL bypass_dbg got %h want 11111111", dbg_data); end
    n_checks++;
    if (fwd_valid !== 1'b1 || fwd_addr !== 5'd3 || fwd_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL bypass_fwd got v=%0b a=%0d d=%h want v=1 a=3 d=deadbeef", fwd_valid, fwd_addr, fwd_data);
    end
    @(posedge clk);
    #1 RegWrite_in = 1'b0;
    #1;
    n_checks++;
    if (dbg_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_stored got %h want deadbeef", dbg_data); end
    n_checks++;
    if (rs_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_rs_after got %h want deadbeef", rs_data); end
  endtask

  task automatic test_zero_reg();
    logic [31:0] c0;
    c0 = wb_count;
    write_addr_in = 5'd0;
    MemToReg_in = 2'b00;
    alu_out_in = 32'hFFFF_FFFF;
    RegWrite_in = 1'b1;
    rs_addr = 5'd0;
    dbg_addr = 5'd0;
    #1;
    n_checks++;
    if (rs_data !== 32'h0) begin n_fail++; $display("FAIL zero_rs got %h want 0", rs_data); end
    n_checks++;
    if (fwd_valid !== 1'b0) begin n_fail++; $display("FAIL zero_fwd_valid got %0b want 0", fwd_valid); end
    @(posedge clk);
    #1 RegWrite_in = 1'b0;
    n_checks++;
    if (wb_count !== c0) begin n_fail++; $display("FAIL zero_count got %0d want %0d", wb_count, c0); end
    n_checks++;
    if (dbg_data !== 32'h0) begin n_fail++; $display("FAIL zero_dbg got %h want 0", dbg_data); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] c0;
    c0 = wb_count;
    write_addr_in = 5'd9;
    MemToReg_in = 2'b00;
    alu_out_in = 32'h1;
    RegWrite_in = 1'b1;
    @(posedge clk);
    #1 alu_out_in = 32'h2;
    @(posedge clk);
    #1 RegWrite_in = 1'b0;
    dbg_addr = 5'd9;
    #1;
    n_checks++;
    if (dbg_data !== 32'h2) begin n_fail++; $display("FAIL b2b_value got %h want 2", dbg_data); end
    n_checks++;
    if (wb_count !== c0 + 32'd2) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", wb_count, c0 + 32'd2); end
  endtask

  task automatic test_async_reset();
    reset_pulse();
    for (int r = 1; r < 32; r++) commit(r[4:0], 2'b10, 32'h0, 32'h0, 32'h0100_0000 + r);
    dbg_addr = 5'd17;
    #1;
    n_checks++;
    if (wb_count !== 32'd31) begin n_fail++; $display("FAIL fill_count got %0d want 31", wb_count); end
    n_checks++;
    if (dbg_data !== 32'h0100_0011) begin n_fail++; $display("FAIL fill_r17 got %h want 01000011", dbg_data); end
    // Pending write to r7 is in flight when reset drops between edges.
    write_addr_in = 5'd7;
    alu_out_in = 32'hCAFE;
    MemToReg_in = 2'b00;
    RegWrite_in = 1'b1;
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (wb_count !== 32'h0) begin n_fail++; $display("FAIL async_count got %0d want 0", wb_count); end
    for (int a = 0; a < 32; a++) begin
      dbg_addr = a[4:0];
      #0.1;
      n_checks++;
      if (dbg_data !== 32'h0) begin n_fail++; $display("FAIL async_dbg r%0d got %h want 0", a, dbg_data); end
    end
    @(posedge clk);
    #1;
    dbg_addr = 5'd7;
    #1;
    n_checks++;
    if (dbg_data !== 32'h0 || wb_count !== 32'h0) begin
      n_fail++; $display("FAIL async_lost_write got r7=%h cnt=%0d want 0 0", dbg_data, wb_count);
    end
    RegWrite_in = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_counter_wrap();
    reset_pulse();
    for (int i = 0; i < 17; i++) commit(5'(1 + (i % 31)), 2'b00, 32'(i), 32'h0, 32'h0);
    #1;
    n_checks++;
    if (wb_count4 !== 4'd1) begin n_fail++; $display("FAIL wrap_count4 got %0d want 1", wb_count4); end
    n_checks++;
    if (wb_count !== 32'd17) begin n_fail++; $display("FAIL wrap_count32 got %0d want 17", wb_count); end
  endtask

  initial begin
    test_reset();
    test_source_select();
    test_bypass();
    test_zero_reg();
    test_back_to_back();
    test_async_reset();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
